chacha_ks_xor: RTL and testbench
================================

# chacha_ks_xor

Keystream-consumer stage directly downstream of the ChaCha20 block-function/serialiser. Latches each 64-byte keystream block from the serialiser's `concatout` bus. XORs it byte-by-byte onto a valid/ready plaintext stream to produce ciphertext. Owns the 32-bit block counter and requests a fresh keystream block from upstream each time 64 bytes have been consumed.

## Interface
Parameters:
- `DATA_SIZE`, 8: byte width of the keystream and data lanes.
- `NO_REG`, 64: bytes per keystream block; must be a power of two.

Ports (`clk` is the single clock; `rst` is an asynchronous, active-low reset):
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a message; honoured only in IDLE.
- `init_counter`  in  32  initial block counter, sampled on `start`.
- `ks_in`  in  [0:NO_REG-1][DATA_SIZE]  keystream bytes (serialiser `concatout`); byte 0 is used first.
- `ks_valid`  in  1  keystream block valid (serialiser `blockready`).
- `ks_req`  out  1  one-cycle pulse requesting the keystream block for `block_counter`.
- `block_counter`  out  32  counter value for the block being requested or consumed.
- `pt_data`  in  DATA_SIZE  plaintext byte.
- `pt_valid`  in  1  plaintext valid.
- `pt_last`  in  1  final byte of the message.
- `pt_ready`  out  1  plaintext accepted this cycle when `pt_valid & pt_ready`.
- `ct_data`  out  DATA_SIZE  ciphertext byte.
- `ct_valid`  out  1  ciphertext valid.
- `ct_last`  out  1  final ciphertext byte.
- `ct_ready`  in  1  downstream ready.
- `busy`  out  1  high in any state other than IDLE.
- `ctr_wrap`  out  1  sticky flag: the block counter wrapped from 0xFFFFFFFF to 0.

## Operation
State machine with three states: IDLE, WAIT_BLK, STREAM.
- **IDLE**
  - On `start`: load `block_counter` from `init_counter`, pulse `ks_req`, clear `ctr_wrap`, and go to WAIT_BLK.
  - All other inputs are ignored.
- **WAIT_BLK**
  - On `ks_valid`: copy `ks_in` into a 64-byte keystream buffer, clear the byte index to 0, and go to STREAM.
  - `pt_ready` is 0 in this state.
- **STREAM**
  - `pt_ready = !ct_valid | ct_ready`.
  - On a plaintext handshake: `ct_data <= pt_data ^ buf[idx]`, `ct_last <= pt_last`, `ct_valid <= 1`, and `idx` increments by one.
  - If the handshake carries `pt_last`: go to IDLE; `block_counter` holds its value.
  - Else if `idx == NO_REG-1`: increment `block_counter` (mod 2^32), pulse `ks_req`, and go to WAIT_BLK.
  - If the counter increments from 0xFFFFFFFF to 0, set `ctr_wrap`; streaming continues.
- **Output register**
  - `ct_valid` clears when `ct_ready & ct_valid` and no new byte is loaded in the same cycle.
  - The output register is allowed to drain while the FSM is in WAIT_BLK or IDLE.
- **Boundary conditions**
  - `pt_last` coinciding with byte 63: IDLE has priority; no `ks_req` is issued.
  - `ks_valid` outside WAIT_BLK: ignored.
  - `start` while busy: ignored.
  - A partial final block discards the unused keystream bytes.
- **Reset** (also applies mid-operation): state returns to IDLE and every output returns to 0: `ks_req`, `block_counter`, `pt_ready`, `ct_data`, `ct_valid`, `ct_last`, `busy`, `ctr_wrap`. Buffer contents are don't-care.

## Timing
- `start` → `ks_req` pulse on the next edge, so the pulse is high the cycle after `start`.
- `ks_valid` sampled high → state is STREAM and `pt_ready` can be high on the following cycle.
- Plaintext handshake → `ct_valid`/`ct_data` registered 1 cycle later.
- Throughput is 1 byte/clk within a block while `ct_ready` is held high.
- Block boundary: `ks_req` is high the cycle after the 64th handshake. The stall then lasts until upstream asserts `ks_valid`, plus 1 cycle.
- `ks_req` is exactly one cycle wide; upstream must hold `ks_in` stable while `ks_valid` is high.

## Structure
- Shared ChaCha package: `word_t`, the `NO_REG`/`DATA_SIZE` defaults, and a state enum `ksx_state_t`.
- One natural sub-module, `ct_out_reg`: a one-entry valid/ready output register holding data and last.
- The keystream buffer and index logic stay in the top module.

## Test plan
1. **RFC 8439 §2.4.2 vector.**
   - Stimulus: key 00..1f, nonce 000000000000004a00000000, `init_counter` = 1, 114-byte "Ladies and Gentlemen…" plaintext, with keystream supplied by a model.
   - Required: ciphertext starts 6e 2e 35 9a; exactly 2 `ks_req` pulses with `block_counter` 1 then 2; `ct_last` on byte 114.
2. **Exact 64-byte message.**
   - Stimulus: `pt_last` on byte 63.
   - Required: exactly one `ks_req`; return to IDLE; `block_counter` still equals `init_counter`.
3. **Backpressure.**
   - Stimulus: random `ct_ready` duty of 30%.
   - Required: no byte lost or duplicated; `pt_ready` low whenever `ct_valid & !ct_ready`.
4. **Counter wrap.**
   - Stimulus: `init_counter` = 0xFFFFFFFF, 130-byte message.
   - Required: second `ks_req` carries `block_counter` = 0; `ctr_wrap` = 1.
5. **Mid-stream reset.**
   - Stimulus: assert `rst` = 0 asynchronously at byte 20.
   - Required: all outputs go to 0 immediately; a subsequent `start` runs test 1 correctly.
6. **Ignored events.**
   - Stimulus: `ks_valid` pulses in IDLE and STREAM; `start` during STREAM.
   - Required: buffer unchanged, no state change, no extra `ks_req`.

Source files
------------

// File: rtl/chacha_ks_xor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chacha_ks_xor_pkg
// Description : Shared types and defaults for the ChaCha keystream XOR stage.
// Revision    : 1.0 - initial release
// ============================================================================
package chacha_ks_xor_pkg;

  // 32-bit ChaCha word, used for the block counter
  typedef logic [31:0] word_t;

  // Default lane width and keystream block size in bytes
  localparam int c_DATA_SIZE_DEF = 8;
  localparam int c_NO_REG_DEF    = 64;

  // Consumer state machine
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BLK = 2'd1,
    S_STREAM   = 2'd2
  } ksx_state_t;

endpackage
`default_nettype wire

// File: rtl/chacha_ks_xor_if.sv
`default_nettype none
// ============================================================================
// Module      : chacha_ks_xor_if
// Description : Plaintext-in / ciphertext-out valid/ready stream bundle.
//               master = stream source and sink (environment),
//               slave  = the XOR stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface chacha_ks_xor_if
  import chacha_ks_xor_pkg::*;
#(
  parameter int DATA_SIZE = c_DATA_SIZE_DEF
);

  logic [DATA_SIZE-1:0] pt_data;
  logic                 pt_valid;
  logic                 pt_last;
  logic                 pt_ready;
  logic [DATA_SIZE-1:0] ct_data;
  logic                 ct_valid;
  logic                 ct_last;
  logic                 ct_ready;

  modport master (
    output pt_data, pt_valid, pt_last, ct_ready,
    input  pt_ready, ct_data, ct_valid, ct_last
  );

  modport slave (
    input  pt_data, pt_valid, pt_last, ct_ready,
    output pt_ready, ct_data, ct_valid, ct_last
  );

endinterface
`default_nettype wire

// File: rtl/chacha_ks_xor_ct_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : chacha_ks_xor_ct_out_reg
// Description : One-entry valid/ready output register holding a ciphertext
//               byte and its last flag. can_load tells the producer that a
//               new byte may be written this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_ks_xor_ct_out_reg #(
  parameter int DATA_SIZE = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 load,
  input  wire logic [DATA_SIZE-1:0] in_data,
  input  wire logic                 in_last,
  input  wire logic                 out_ready,
  output logic                      out_valid,
  output logic [DATA_SIZE-1:0]      out_data,
  output logic                      out_last,
  output logic                      can_load
);

  logic                 r_valid;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_last;

  // Load a new byte, otherwise drop valid once the consumer takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
      r_last  <= in_last;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign can_load  = !r_valid | out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/chacha_ks_xor.sv
`default_nettype none
// ============================================================================
// Module      : chacha_ks_xor
// Description : Latches 64-byte ChaCha keystream blocks and XORs them onto a
//               valid/ready plaintext stream. Owns the 32-bit block counter
//               and requests a fresh block after each full block consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_ks_xor
  import chacha_ks_xor_pkg::*;
#(
  parameter int DATA_SIZE = c_DATA_SIZE_DEF,
  parameter int NO_REG    = c_NO_REG_DEF
) (
  input  wire logic                               clk,
  input  wire logic                               rst,
  input  wire logic                               start,
  input  wire word_t                              init_counter,
  input  wire logic [0:NO_REG-1][DATA_SIZE-1:0]   ks_in,
  input  wire logic                               ks_valid,
  output logic                                    ks_req,
  output word_t                                   block_counter,
  output logic                                    busy,
  output logic                                    ctr_wrap,
  chacha_ks_xor_if.slave                          strm
);

  localparam int                 c_IDX_W    = $clog2(NO_REG);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NO_REG - 1);

  ksx_state_t                         r_state;
  word_t                              r_ctr;
  logic                               r_ks_req;
  logic                               r_wrap;
  logic [c_IDX_W-1:0]                 r_idx;
  logic [0:NO_REG-1][DATA_SIZE-1:0]   r_buf;

  logic                 w_can_load;
  logic                 w_pt_ready;
  logic                 w_hs;
  logic [DATA_SIZE-1:0] w_ct_byte;

  assign w_pt_ready = (r_state == S_STREAM) & w_can_load;
  assign w_hs       = strm.pt_valid & w_pt_ready;
  assign w_ct_byte  = strm.pt_data ^ r_buf[r_idx];

  // Control FSM: counter ownership, keystream requests and byte index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ctr    <= '0;
      r_ks_req <= 1'b0;
      r_wrap   <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_ks_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ctr    <= init_counter;
            r_ks_req <= 1'b1;
            r_wrap   <= 1'b0;
            r_state  <= S_WAIT_BLK;
          end
        end
        S_WAIT_BLK: begin
          if (ks_valid) begin
            r_idx   <= '0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            r_idx <= r_idx + 1'b1;
            // Message end wins over block end: no request for an unused block
            if (strm.pt_last) begin
              r_state <= S_IDLE;
            end else if (r_idx == c_IDX_LAST) begin
              r_ctr    <= r_ctr + 1'b1;
              r_ks_req <= 1'b1;
              r_state  <= S_WAIT_BLK;
              if (r_ctr == '1) begin
                r_wrap <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Keystream buffer: captured only when a block is awaited, contents need no reset
  always_ff @(posedge clk) begin
    if ((r_state == S_WAIT_BLK) && ks_valid) begin
      r_buf <= ks_in;
    end
  end

  chacha_ks_xor_ct_out_reg #(
    .DATA_SIZE (DATA_SIZE)
  ) u_ct_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_hs),
    .in_data   (w_ct_byte),
    .in_last   (strm.pt_last),
    .out_ready (strm.ct_ready),
    .out_valid (strm.ct_valid),
    .out_data  (strm.ct_data),
    .out_last  (strm.ct_last),
    .can_load  (w_can_load)
  );

  assign strm.pt_ready = w_pt_ready;
  assign ks_req        = r_ks_req;
  assign block_counter = r_ctr;
  assign busy          = (r_state != S_IDLE);
  assign ctr_wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_chacha_ks_xor.sv
`default_nettype none
// ============================================================================
// Module      : tb_chacha_ks_xor
// Description : Self-checking bench for chacha_ks_xor with a ChaCha20 block
//               model as keystream source and a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_ks_xor;

  typedef logic [0:63][7:0] blk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] init_counter;
  blk_t        up_ks;
  logic        up_valid;
  logic        spur_valid;
  blk_t        ks_in;
  logic        ks_valid;
  logic        ks_req;
  logic [31:0] block_counter;
  logic        busy;
  logic        ctr_wrap;
  bit          bp_mode;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0]  exp_q [$];
  logic [7:0]  cap_q [$];
  logic [31:0] req_log [$];
  logic [7:0]  msg [$];

  chacha_ks_xor_if #(.DATA_SIZE(8)) s_if ();

  // Spurious pulses carry garbage keystream so a wrongly taken block shows up
  assign ks_valid = up_valid | spur_valid;
  assign ks_in    = spur_valid ? {64{8'hFF}} : up_ks;

  chacha_ks_xor #(.DATA_SIZE(8), .NO_REG(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .init_counter  (init_counter),
    .ks_in         (ks_in),
    .ks_valid      (ks_valid),
    .ks_req        (ks_req),
    .block_counter (block_counter),
    .busy          (busy),
    .ctr_wrap      (ctr_wrap),
    .strm          (s_if)
  );

  always #5 clk = ~clk;

  // ---------------- ChaCha20 block model (key 00..1f, nonce ..4a..) --------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void qr(inout logic [31:0] a, inout logic [31:0] b,
                             inout logic [31:0] c, inout logic [31:0] d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
  endfunction

  function automatic blk_t chacha_blk(input logic [31:0] ctr);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] w;
    blk_t        r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      s[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    s[12] = ctr; s[13] = 32'h0; s[14] = 32'h4a000000; s[15] = 32'h0;
    for (int i = 0; i < 16; i++) x[i] = s[i];
    for (int rd = 0; rd < 10; rd++) begin
      qr(x[0], x[4], x[8],  x[12]);
      qr(x[1], x[5], x[9],  x[13]);
      qr(x[2], x[6], x[10], x[14]);
      qr(x[3], x[7], x[11], x[15]);
      qr(x[0], x[5], x[10], x[15]);
      qr(x[1], x[6], x[11], x[12]);
      qr(x[2], x[7], x[8],  x[13]);
      qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) begin
      w = x[i] + s[i];
      r[4*i]   = w[7:0];
      r[4*i+1] = w[15:8];
      r[4*i+2] = w[23:16];
      r[4*i+3] = w[31:24];
    end
    return r;
  endfunction

  // ---------------- checking helpers --------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ks_req"},   {31'b0, ks_req}, 32'h0);
    check({tag, "_blk_ctr"},  block_counter, 32'h0);
    check({tag, "_pt_ready"}, {31'b0, s_if.pt_ready}, 32'h0);
    check({tag, "_ct_data"},  {24'b0, s_if.ct_data}, 32'h0);
    check({tag, "_ct_valid"}, {31'b0, s_if.ct_valid}, 32'h0);
    check({tag, "_ct_last"},  {31'b0, s_if.ct_last}, 32'h0);
    check({tag, "_busy"},     {31'b0, busy}, 32'h0);
    check({tag, "_ctr_wrap"}, {31'b0, ctr_wrap}, 32'h0);
  endtask

  // Monitor: scoreboard pops, backpressure rule, ks_req log
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (s_if.ct_valid && s_if.ct_ready) begin
        if (exp_q.size() == 0) begin
          check("ct_unexpected_byte", {23'b0, s_if.ct_last, s_if.ct_data}, 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          cap_q.push_back(s_if.ct_data);
          check("ct_byte", {23'b0, s_if.ct_last, s_if.ct_data}, {23'b0, e});
        end
      end
      if (s_if.ct_valid && !s_if.ct_ready)
        check("pt_ready_under_stall", {31'b0, s_if.pt_ready}, 32'h0);
      if (ks_req)
        req_log.push_back(block_counter);
    end
  end

  // Upstream keystream source: answers each request three cycles later
  initial begin
    logic [31:0] c;
    up_valid = 1'b0;
    up_ks    = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ks_req === 1'b1) begin
        c = block_counter;
        repeat (3) @(posedge clk);
        #1;
        up_ks    = chacha_blk(c);
        up_valid = 1'b1;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
      end
    end
  end

  // Downstream ready: always high, or ~30% duty under backpressure
  initial begin
    s_if.ct_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_if.ct_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // ---------------- stimulus tasks ----------------------------------------
  task automatic prep(input logic [31:0] init);
    int   len;
    blk_t b;
    len = msg.size();
    exp_q.delete(); cap_q.delete(); req_log.delete();
    for (int k = 0; k < (len + 63) / 64; k++) begin
      b = chacha_blk(init + 32'(k));
      for (int j = 0; j < 64; j++)
        if (k*64 + j < len)
          exp_q.push_back({(k*64 + j == len - 1), msg[k*64+j] ^ b[j]});
    end
  endtask

  task automatic do_start(input logic [31:0] init);
    @(posedge clk); #1;
    init_counter = init;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic send_msg(input int abort_at);
    int i = 0;
    int guard = 0;
    bit hs;
    int len;
    len = msg.size();
    s_if.pt_valid = 1'b1;
    s_if.pt_data  = msg[0];
    s_if.pt_last  = (len == 1);
    while (i < len && i != abort_at) begin
      @(negedge clk);
      hs = s_if.pt_valid && s_if.pt_ready;
      @(posedge clk); #1;
      if (hs) begin
        i++;
        if (i < len && i != abort_at) begin
          s_if.pt_data = msg[i];
          s_if.pt_last = (i == len - 1);
        end else begin
          s_if.pt_valid = 1'b0;
          s_if.pt_last  = 1'b0;
        end
      end
      guard++;
      if (guard > 5000) begin
        check("send_timeout", i, len);
        s_if.pt_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_left_in_queue"}, exp_q.size(), 32'h0);
    check({tag, "_busy_end"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic load_rfc();
    string s;
    s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s.getc(i));
  endtask

  task automatic run_rfc(input string tag);
    load_rfc();
    prep(32'd1);
    do_start(32'd1);
    send_msg(-1);
    drain(tag);
    check({tag, "_ct0"}, {24'b0, cap_q[0]}, 32'h6e);
    check({tag, "_ct1"}, {24'b0, cap_q[1]}, 32'h2e);
    check({tag, "_ct2"}, {24'b0, cap_q[2]}, 32'h35);
    check({tag, "_ct3"}, {24'b0, cap_q[3]}, 32'h9a);
    check({tag, "_n_ct"}, cap_q.size(), 32'd114);
    check({tag, "_n_req"}, req_log.size(), 32'd2);
    check({tag, "_req0"}, req_log[0], 32'd1);
    check({tag, "_req1"}, req_log[1], 32'd2);
  endtask

  // Watchdog: the run must never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    rst = 1'b0; start = 1'b0; init_counter = '0; bp_mode = 1'b0;
    spur_valid = 1'b0;
    s_if.pt_valid = 1'b0; s_if.pt_data = '0; s_if.pt_last = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // 1: RFC 8439 2.4.2 vector
    run_rfc("rfc");

    // 2: exact 64-byte message
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i * 3 + 1));
    prep(32'h10);
    do_start(32'h10);
    send_msg(-1);
    drain("m64");
    check("m64_n_req", req_log.size(), 32'd1);
    check("m64_blk_ctr", block_counter, 32'h10);

    // 3: backpressure
    msg.delete();
    for (int i = 0; i < 150; i++) msg.push_back(8'($urandom_range(0, 255)));
    bp_mode = 1'b1;
    prep(32'd5);
    do_start(32'd5);
    send_msg(-1);
    drain("bp");
    bp_mode = 1'b0;
    check("bp_n_req", req_log.size(), 32'd3);

    // 4: counter wrap
    msg.delete();
    for (int i = 0; i < 130; i++) msg.push_back(8'(255 - i));
    prep(32'hFFFF_FFFF);
    do_start(32'hFFFF_FFFF);
    send_msg(-1);
    drain("wrap");
    check("wrap_n_req", req_log.size(), 32'd3);
    check("wrap_req0", req_log[0], 32'hFFFF_FFFF);
    check("wrap_req1", req_log[1], 32'h0);
    check("wrap_flag", {31'b0, ctr_wrap}, 32'h1);
    check("wrap_blk_ctr", block_counter, 32'h1);

    // 5: asynchronous reset at byte 20, then a clean RFC run
    load_rfc();
    prep(32'd1);
    do_start(32'd1);
    send_msg(20);
    #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    run_rfc("after_rst");

    // 6: ignored ks_valid (IDLE and STREAM) and start while busy
    req_log.delete();
    @(posedge clk); #1 spur_valid = 1'b1;
    @(posedge clk); #1 spur_valid = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", {31'b0, busy}, 32'h0);
    check("ign_idle_req", req_log.size(), 32'h0);
    msg.delete();
    for (int i = 0; i < 100; i++) msg.push_back(8'(i ^ 8'h5A));
    prep(32'h20);
    do_start(32'h20);
    fork
      send_msg(-1);
      begin
        repeat (30) @(posedge clk);
        #1;
        spur_valid   = 1'b1;
        init_counter = 32'h999;
        start        = 1'b1;
        @(posedge clk); #1;
        spur_valid = 1'b0;
        start      = 1'b0;
      end
    join
    drain("ign");
    check("ign_n_req", req_log.size(), 32'd2);
    check("ign_req0", req_log[0], 32'h20);
    check("ign_req1", req_log[1], 32'h21);
    check("ign_blk_ctr", block_counter, 32'h21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
